data_memory_param: RTL and testbench

- Parametrised, cycle-accurate successor to the fixed 128-bit block data memory that sits behind the data cache.
- Serves whole-block reads and word-masked block writes over the existing READ/WRITE/BUSYWAIT handshake.
- Access latency is set by a programmable cycle counter, not by intra-assignment delays.
- Flags illegal requests (read and write together, address out of range) on an ERROR output.

---
 rtl/data_memory_param.sv | 155 +++++++++++++++
 tb/tb_data_memory_param.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Parametrised block data memory behind the data cache.
// Whole-block reads and word-masked block writes over a READ/WRITE/BUSYWAIT
// handshake. Access latency comes from a down-counter, and illegal requests
// are reported on ERROR.
module data_memory_param #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LATENCY     = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        ADDRESS,
  input  logic [32*BLOCK_WORDS-1:0] WRITEDATA,
  input  logic [BLOCK_WORDS-1:0]   WORD_MASK,
  output logic [32*BLOCK_WORDS-1:0] READDATA,
  output logic                     BUSYWAIT,
  output logic                     ERROR
);

  localparam int unsigned BlockW = 32 * BLOCK_WORDS;
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      CntInit  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BlockW-1:0]      wdata_q, wdata_d;
  logic [BLOCK_WORDS-1:0] mask_q, mask_d;
  logic                   op_wr_q, op_wr_d;
  logic [BlockW-1:0]      rdata_q, rdata_d;
  logic                   error_q, error_d;

  logic [BlockW-1:0]      mem_q [DEPTH];

  logic                   single_req;
  logic                   both_req;
  logic                   in_range;
  logic                   mem_we;
  logic [IdxW-1:0]        idx;

  assign single_req = READ ^ WRITE;
  assign both_req   = READ & WRITE;
  assign in_range   = ({1'b0, addr_q} < DepthLim);
  assign idx        = addr_q[IdxW-1:0];

  // Stall while busy, or while a single request is being presented in idle.
  assign BUSYWAIT = (state_q == StBusy) || ((state_q == StIdle) && single_req);
  assign READDATA = rdata_q;
  assign ERROR    = error_q;

  // Next-state, request latching, latency countdown and access decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    error_d = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (single_req) begin
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
          mask_d  = WORD_MASK;
          op_wr_d = WRITE;
          cnt_d   = CntInit;
          state_d = StBusy;
        end else if (both_req) begin
          // Conflicting request: refused, flagged for one cycle.
          error_d = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StDone;
          if (!in_range) begin
            // Out-of-range: reads return zero, writes are dropped.
            error_d = 1'b1;
            if (!op_wr_q) begin
              rdata_d = '0;
            end
          end else if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx];
          end
        end
      end
      StDone: begin
        // Requests seen here are ignored; idle samples them next edge.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Storage array: cleared on reset, word-masked update on a completed write.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      for (int k = 0; k < int'(BLOCK_WORDS); k++) begin
        if (mask_q[k]) begin
          mem_q[idx][32*k +: 32] <= wdata_q[32*k +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench for data_memory_param: default instance (4 words,
// 1024 blocks, latency 5) plus a small instance (8 words, 16 blocks, latency 1).
module tb_data_memory_param;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic         a_read, a_write;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [3:0]   a_mask;
  logic         a_busy, a_err;

  // Small instance
  logic         b_read, b_write;
  logic [27:0]  b_addr;
  logic [255:0] b_wdata, b_rdata;
  logic [7:0]   b_mask;
  logic         b_busy, b_err;

  data_memory_param u_dut_a (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .READ      (a_read),
    .WRITE     (a_write),
    .ADDRESS   (a_addr),
    .WRITEDATA (a_wdata),
    .WORD_MASK (a_mask),
    .READDATA  (a_rdata),
    .BUSYWAIT  (a_busy),
    .ERROR     (a_err)
  );

  data_memory_param #(
    .ADDR_W      (28),
    .BLOCK_WORDS (8),
    .DEPTH       (16),
    .LATENCY     (1)
  ) u_dut_b (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .READ      (b_read),
    .WRITE     (b_write),
    .ADDRESS   (b_addr),
    .WRITEDATA (b_wdata),
    .WORD_MASK (b_mask),
    .READDATA  (b_rdata),
    .BUSYWAIT  (b_busy),
    .ERROR     (b_err)
  );

  // Reference model: sparse block store per instance, absent entries read as 0.
  logic [255:0] mdl_a [int];
  logic [255:0] mdl_b [int];

  function automatic logic [255:0] mdl_read(input bit sel, input logic [27:0] a);
    int depth = sel ? 16 : 1024;
    if (int'(a) >= depth) return '0;
    if (sel) return mdl_b.exists(int'(a)) ? mdl_b[int'(a)] : '0;
    return mdl_a.exists(int'(a)) ? mdl_a[int'(a)] : '0;
  endfunction

  function automatic void mdl_write(input bit sel, input logic [27:0] a,
                                    input logic [255:0] wd, input logic [7:0] m);
    int depth = sel ? 16 : 1024;
    int words = sel ? 8 : 4;
    logic [255:0] v;
    if (int'(a) >= depth) return;
    v = mdl_read(sel, a);
    for (int k = 0; k < words; k++) begin
      if (m[k]) v[32*k +: 32] = wd[32*k +: 32];
    end
    if (sel) mdl_b[int'(a)] = v;
    else     mdl_a[int'(a)] = v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Presents one request (entered #1 after a rising edge with the DUT idle),
  // counts BUSYWAIT-high cycles, samples outputs in the first non-busy cycle,
  // and returns #1 after the following rising edge.
  task automatic do_access(input bit sel, input bit is_wr, input logic [27:0] a,
                           input logic [255:0] wd, input logic [7:0] m, input bit hold,
                           output int nbusy, output logic [255:0] rd, output logic er,
                           output logic er_busy, output int done_cyc);
    if (!sel) begin
      a_read = !is_wr; a_write = is_wr; a_addr = a; a_wdata = wd[127:0]; a_mask = m[3:0];
    end else begin
      b_read = !is_wr; b_write = is_wr; b_addr = a; b_wdata = wd; b_mask = m;
    end
    nbusy = 0;
    er_busy = 1'b0;
    @(negedge clk);
    while ((sel ? b_busy : a_busy) && nbusy < 400) begin
      nbusy++;
      if (sel ? b_err : a_err) er_busy = 1'b1;
      @(negedge clk);
    end
    rd = sel ? b_rdata : {128'b0, a_rdata};
    er = sel ? b_err : a_err;
    done_cyc = cyc;
    if (!hold) begin
      if (!sel) begin a_read = 1'b0; a_write = 1'b0; end
      else      begin b_read = 1'b0; b_write = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_mask = '0;
    b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_mask = '0;
    mdl_a.delete();
    mdl_b.delete();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_busy, a_err, a_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: busy=%b err=%b rdata=%h, required all zero", a_busy, a_err, a_rdata);
    end
    n_cmp++;
    if ({b_busy, b_err, b_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: busy=%b err=%b rdata=%h, required all zero", b_busy, b_err, b_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_after_reset();
    int nb, dc;
    logic [255:0] rd;
    logic er, eb;
    do_access(0, 0, 28'd5, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (nb !== 6) begin
      n_bad++; $display("FAIL rd5_busy_cycles: got %0d, required 6", nb);
    end
    n_cmp++;
    if ({er, eb, rd} !== '0) begin
      n_bad++; $display("FAIL rd5_data_err: err=%b errbusy=%b rd=%h, required zeros", er, eb, rd);
    end
  endtask

  task automatic test_masked_write();
    int nb, dc;
    logic [255:0] rd;
    logic er, eb;
    logic [127:0] exp_blk = 128'hDDDDDDDD_11111111_BBBBBBBB_11111111;
    do_access(0, 1, 28'd3, {128'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA}, 8'h0F, 0,
              nb, rd, er, eb, dc);
    mdl_write(0, 28'd3, {128'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA}, 8'h0F);
    n_cmp++;
    if (nb !== 6 || er !== 1'b0) begin
      n_bad++; $display("FAIL wr_full: busy=%0d err=%b, required 6 and 0", nb, er);
    end
    do_access(0, 1, 28'd3, {128'b0, {4{32'h11111111}}}, 8'h05, 0, nb, rd, er, eb, dc);
    mdl_write(0, 28'd3, {128'b0, {4{32'h11111111}}}, 8'h05);
    do_access(0, 0, 28'd3, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (rd[127:0] !== exp_blk) begin
      n_bad++; $display("FAIL wr_masked_readback: got %h, required %h", rd[127:0], exp_blk);
    end
  endtask

  task automatic test_back_to_back();
    int nb1, nb2, dc1, dc2;
    logic [255:0] rd1, rd2, wd;
    logic er, eb;
    wd = {128'b0, rand256()[127:0]};
    do_access(0, 1, 28'd10, wd, 8'h0F, 0, nb1, rd1, er, eb, dc1);
    mdl_write(0, 28'd10, wd, 8'h0F);
    do_access(0, 0, 28'd10, '0, '0, 1, nb1, rd1, er, eb, dc1);
    do_access(0, 0, 28'd3, '0, '0, 0, nb2, rd2, er, eb, dc2);
    n_cmp++;
    if (dc2 - dc1 !== 7) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d cycles, required 7", dc2 - dc1);
    end
    n_cmp++;
    if (nb1 !== 6 || nb2 !== 6) begin
      n_bad++; $display("FAIL b2b_busy: got %0d/%0d, required 6/6", nb1, nb2);
    end
    n_cmp++;
    if (rd1 !== mdl_read(0, 28'd10) || rd2 !== mdl_read(0, 28'd3)) begin
      n_bad++;
      $display("FAIL b2b_data: got %h / %h, required %h / %h", rd1[127:0], rd2[127:0],
               mdl_read(0, 28'd10), mdl_read(0, 28'd3));
    end
  endtask

  task automatic test_illegal();
    int nb, dc;
    logic [255:0] rd;
    logic er, eb;
    a_read = 1; a_write = 1; a_addr = 28'd3; a_wdata = '1; a_mask = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_err !== 1'b0) begin
      n_bad++; $display("FAIL both_pre: busy=%b err=%b, required 0 0", a_busy, a_err);
    end
    @(posedge clk);
    #1;
    a_read = 0; a_write = 0;
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_err !== 1'b1) begin
      n_bad++; $display("FAIL both_flag: busy=%b err=%b, required 0 1", a_busy, a_err);
    end
    @(negedge clk);
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_bad++; $display("FAIL both_flag_len: err=%b, required 0", a_err);
    end
    @(posedge clk);
    #1;
    do_access(0, 0, 28'd3, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (rd !== mdl_read(0, 28'd3)) begin
      n_bad++; $display("FAIL both_mem_kept: got %h, required %h", rd[127:0], mdl_read(0, 28'd3));
    end
    do_access(0, 0, 28'd1024, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (nb !== 6 || rd !== '0 || er !== 1'b1 || eb !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_read: busy=%0d rd=%h err=%b errbusy=%b, required 6 0 1 0",
               nb, rd[127:0], er, eb);
    end
    @(negedge clk);
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_bad++; $display("FAIL oor_err_len: err=%b, required 0", a_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_write();
    int nb, dc;
    logic [255:0] rd;
    logic er, eb;
    do_access(0, 0, 28'd3, '0, '0, 0, nb, rd, er, eb, dc);
    a_write = 1; a_addr = 28'd7; a_wdata = rand256()[127:0]; a_mask = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    a_write = 0;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({a_busy, a_err, a_rdata} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: busy=%b err=%b rdata=%h, required zeros", a_busy, a_err,
               a_rdata);
    end
    mdl_a.delete();
    mdl_b.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_busy: got %b, required 0", a_busy);
    end
    @(posedge clk);
    #1;
    do_access(0, 0, 28'd7, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (rd !== '0 || nb !== 6) begin
      n_bad++; $display("FAIL midrst_addr7: rd=%h busy=%0d, required 0 and 6", rd[127:0], nb);
    end
  endtask

  task automatic test_random(input bit sel, input int n_ops);
    int nb, dc, lat;
    logic [255:0] rd, wd, exp_rd;
    logic er, eb, wr, exp_er;
    logic [27:0] a;
    logic [7:0] m;
    lat = sel ? 1 : 5;
    for (int i = 0; i < n_ops; i++) begin
      wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) a = 28'((sel ? 16 : 1024) + $urandom_range(0, 40));
      else a = 28'($urandom_range(0, sel ? 15 : 31));
      wd = sel ? rand256() : {128'b0, rand256()[127:0]};
      m  = sel ? 8'($urandom) : {4'b0, 4'($urandom)};
      exp_rd = wr ? '0 : mdl_read(sel, a);
      exp_er = int'(a) >= (sel ? 16 : 1024);
      do_access(sel, wr, a, wd, m, 0, nb, rd, er, eb, dc);
      if (wr) mdl_write(sel, a, wd, m);
      n_cmp++;
      if (nb !== lat + 1 || er !== exp_er || eb !== 1'b0) begin
        n_bad++;
        $display("FAIL rand%0d_ctl op%0d: busy=%0d err=%b errbusy=%b, required %0d %b 0",
                 sel, i, nb, er, eb, lat + 1, exp_er);
      end
      if (!wr) begin
        n_cmp++;
        if (rd !== exp_rd) begin
          n_bad++;
          $display("FAIL rand%0d_data op%0d addr %0d: got %h, required %h", sel, i, a, rd, exp_rd);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int nb, dc;
    logic [255:0] rd, wd;
    logic er, eb;
    wd = rand256();
    do_access(1, 1, 28'd9, wd, 8'hFF, 0, nb, rd, er, eb, dc);
    mdl_write(1, 28'd9, wd, 8'hFF);
    n_cmp++;
    if (nb !== 2) begin
      n_bad++; $display("FAIL sweep_busy: got %0d, required 2", nb);
    end
    do_access(1, 0, 28'd9, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (rd !== wd || er !== 1'b0) begin
      n_bad++; $display("FAIL sweep_roundtrip: got %h err=%b, required %h 0", rd, er, wd);
    end
    do_access(1, 0, 28'd16, '0, '0, 0, nb, rd, er, eb, dc);
    n_cmp++;
    if (rd !== '0 || er !== 1'b1 || nb !== 2) begin
      n_bad++; $display("FAIL sweep_oor: rd=%h err=%b busy=%0d, required 0 1 2", rd, er, nb);
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_masked_write();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
    test_sweep();
    test_random(0, 30);
    test_random(1, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
